layer_serializer: RTL and testbench

- Consumes one layer's parallel neuron outputs (NN words plus per-neuron valids) and replays them as a serial word stream.
- The stream feeds the next layer's single-word x_in / x_valid input, with an optional downstream ready.
- Sits between consecutive fully-connected layers in the network top.
- Single-entry capture buffer, element counter, 3-state FSM.

---
 rtl/layer_serializer.sv | 161 ++++++++++++++++
 tb/tb_layer_serializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/layer_serializer.sv
// Captures one layer's NN parallel neuron words and replays them as a serial stream with valid/ready/last.
// Define LAYER_SERIALIZER_ARGMAX_EN to add a running signed argmax over the streamed words (o_max_idx/o_max_valid).
module layer_serializer #(
  parameter int NN        = 10,
  parameter int dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           i_valid,
  input  logic [NN*dataWidth-1:0] i_data,
  output logic                    o_valid,
  output logic [dataWidth-1:0]    o_data,
  input  logic                    o_ready,
  output logic                    o_last,
  output logic                    busy,
`ifdef LAYER_SERIALIZER_ARGMAX_EN
  output logic [$clog2(NN)-1:0]   o_max_idx,
  output logic                    o_max_valid,
`endif
  output logic                    overrun
);

  localparam int              CW       = $clog2(NN);
  localparam logic [CW-1:0]   LAST_IDX = CW'(NN - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  state_t                  r_state;
  logic [NN*dataWidth-1:0] r_buf;
  logic [CW-1:0]           r_cnt;
  logic                    r_valid;
  logic                    r_last;
  logic                    r_busy;
  logic                    r_overrun;
  logic [dataWidth-1:0]    r_data;

  logic [dataWidth-1:0]    w_words [NN];
  logic [CW-1:0]           w_cntNext;
  logic                    w_hs;
  logic                    w_lastHs;
  logic                    w_cap;
  logic                    w_unusedValid;

`ifdef LAYER_SERIALIZER_ARGMAX_EN
  logic [dataWidth-1:0]    r_runMax;
  logic [CW-1:0]           r_runIdx;
  logic [CW-1:0]           r_maxIdx;
  logic                    r_maxValid;
  logic                    w_better;
  logic [CW-1:0]           w_bestIdx;

  // Strict greater-than keeps the earliest index on ties.
  assign w_better  = (r_cnt == '0) || ($signed(r_data) > $signed(r_runMax));
  assign w_bestIdx = w_better ? r_cnt : r_runIdx;
  assign o_max_idx   = r_maxIdx;
  assign o_max_valid = r_maxValid;
`endif

  genvar k;
  generate
    for (k = 0; k < NN; k++) begin : g_words
      assign w_words[k] = r_buf[k*dataWidth +: dataWidth];
    end
  endgenerate

  // Only bit 0 of i_valid qualifies a capture; the rest carry no control meaning.
  assign w_unusedValid = ^i_valid[NN-1:1];
  assign w_cap         = i_valid[0];
  assign w_hs          = r_valid & o_ready;
  assign w_lastHs      = w_hs & r_last;
  assign w_cntNext     = r_cnt + 1'b1;

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign busy    = r_busy;
  assign overrun = r_overrun;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_buf     <= '0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
`ifdef LAYER_SERIALIZER_ARGMAX_EN
      r_runMax   <= '0;
      r_runIdx   <= '0;
      r_maxIdx   <= '0;
      r_maxValid <= 1'b0;
`endif
    end else begin
`ifdef LAYER_SERIALIZER_ARGMAX_EN
      r_maxValid <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_cap) begin
            r_buf   <= i_data;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end

        LOAD: begin
          if (w_cap) r_overrun <= 1'b1;
          r_cnt   <= '0;
          r_valid <= 1'b1;
          r_data  <= w_words[0];
          r_last  <= 1'b0;
          r_state <= SEND;
        end

        SEND: begin
`ifdef LAYER_SERIALIZER_ARGMAX_EN
          if (w_hs) begin
            r_runIdx <= w_bestIdx;
            if (w_better) r_runMax <= r_data;
          end
          if (w_lastHs) begin
            r_maxIdx   <= w_bestIdx;
            r_maxValid <= 1'b1;
          end
`endif
          if (w_lastHs) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
            // A capture landing exactly on the final handshake is a legal back-to-back result.
            if (w_cap) begin
              r_buf   <= i_data;
              r_state <= LOAD;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            if (w_cap) r_overrun <= 1'b1;
            if (w_hs) begin
              r_cnt  <= w_cntNext;
              r_data <= w_words[w_cntNext];
              r_last <= (w_cntNext == LAST_IDX);
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_serializer.sv
// Directed self-checking bench for layer_serializer (NN=10, dataWidth=16).
// Argmax checks compile in when LAYER_SERIALIZER_ARGMAX_EN is defined.
module tb_layer_serializer;

  localparam int NN = 10;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NN-1:0]    i_valid;
  logic [NN*DW-1:0] i_data;
  logic             o_valid;
  logic [DW-1:0]    o_data;
  logic             o_ready;
  logic             o_last;
  logic             busy;
  logic             overrun;
`ifdef LAYER_SERIALIZER_ARGMAX_EN
  logic [3:0]       o_max_idx;
  logic             o_max_valid;
`endif

  int testsRun    = 0;
  int testsFailed = 0;
  int hs;
  logic [DW-1:0] expWords [NN];

  layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .clk(clk),
    .rst(rst),
    .i_valid(i_valid),
    .i_data(i_data),
    .o_valid(o_valid),
    .o_data(o_data),
    .o_ready(o_ready),
    .o_last(o_last),
    .busy(busy),
`ifdef LAYER_SERIALIZER_ARGMAX_EN
    .o_max_idx(o_max_idx),
    .o_max_valid(o_max_valid),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [NN*DW-1:0] packExp();
    logic [NN*DW-1:0] r;
    for (int j = 0; j < NN; j++) r[j*DW +: DW] = expWords[j];
    return r;
  endfunction

  function automatic logic [NN*DW-1:0] packRamp(input logic [DW-1:0] base);
    logic [NN*DW-1:0] r;
    for (int j = 0; j < NN; j++) r[j*DW +: DW] = base + DW'(j);
    return r;
  endfunction

  task automatic setRamp(input logic [DW-1:0] base);
    for (int j = 0; j < NN; j++) expWords[j] = base + DW'(j);
  endtask

  task automatic setBasic;
    for (int j = 0; j < NN; j++) expWords[j] = DW'(16 * j + 1);
  endtask

  // Pulses a capture for one clock edge with the given word set.
  task automatic applyStimulus(input logic [NN*DW-1:0] data);
    i_data  = data;
    i_valid = '1;
    stepCycle;
    i_valid = '0;
  endtask

  // Expects a live stream; checks each presented word against expWords until maxWords handshakes.
  task automatic streamWords(input string tag, input bit useBp, input int capAt,
                             input logic [DW-1:0] capBase, input int maxWords, output int hsCount);
    int idx = 0;
    int cyc = 0;
    bit capDone = 1'b0;
    while (idx < maxWords && cyc < 200) begin
      o_ready = useBp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      checkOutput($sformatf("%s_valid%0d", tag, idx), {31'd0, o_valid}, 32'd1);
      checkOutput($sformatf("%s_data%0d", tag, idx), {16'd0, o_data}, {16'd0, expWords[idx]});
      checkOutput($sformatf("%s_last%0d", tag, idx), {31'd0, o_last}, {31'd0, idx == NN - 1});
      if (idx == capAt && !capDone) begin
        i_data  = packRamp(capBase);
        i_valid = '1;
        capDone = 1'b1;
      end
      if (o_valid && o_ready) idx++;
      stepCycle;
      i_valid = '0;
      cyc++;
    end
    hsCount = idx;
    o_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; i_valid = '0; i_data = '0; o_ready = 1'b1;
    #1 rst = 1'b0;
    #2;
    checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("rst_data", {16'd0, o_data}, 32'd0);
    checkOutput("rst_last", {31'd0, o_last}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
`ifdef LAYER_SERIALIZER_ARGMAX_EN
    checkOutput("rst_maxIdx", {28'd0, o_max_idx}, 32'd0);
    checkOutput("rst_maxValid", {31'd0, o_max_valid}, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    stepCycle;

    // Basic drain with free-running ready.
    setBasic;
    applyStimulus(packExp());
    checkOutput("basic_loadValid", {31'd0, o_valid}, 32'd0);
    checkOutput("basic_loadBusy", {31'd0, busy}, 32'd1);
    stepCycle;
    streamWords("basic", 1'b0, -1, '0, NN, hs);
    checkOutput("basic_hs", hs, NN);
    checkOutput("basic_endValid", {31'd0, o_valid}, 32'd0);
    checkOutput("basic_endData", {16'd0, o_data}, 32'd0);
    checkOutput("basic_endBusy", {31'd0, busy}, 32'd0);
`ifdef LAYER_SERIALIZER_ARGMAX_EN
    checkOutput("basic_maxValid", {31'd0, o_max_valid}, 32'd1);
    checkOutput("basic_maxIdx", {28'd0, o_max_idx}, 32'd9);
`endif
    stepCycle;

    // Backpressure with ready pattern 1,0,0,1.
    applyStimulus(packExp());
    stepCycle;
    streamWords("bp", 1'b1, -1, '0, NN, hs);
    checkOutput("bp_hs", hs, NN);
    checkOutput("bp_endValid", {31'd0, o_valid}, 32'd0);
    checkOutput("bp_endBusy", {31'd0, busy}, 32'd0);
    stepCycle;

    // Back-to-back capture on the final handshake.
    applyStimulus(packExp());
    stepCycle;
    streamWords("b2b1", 1'b0, NN - 1, 16'hA000, NN, hs);
    checkOutput("b2b_gapValid", {31'd0, o_valid}, 32'd0);
    checkOutput("b2b_gapBusy", {31'd0, busy}, 32'd1);
    checkOutput("b2b_overrun", {31'd0, overrun}, 32'd0);
    setRamp(16'hA000);
    stepCycle;
    streamWords("b2b2", 1'b0, -1, '0, NN, hs);
    checkOutput("b2b2_hs", hs, NN);
    checkOutput("b2b2_endBusy", {31'd0, busy}, 32'd0);
    checkOutput("b2b2_overrun", {31'd0, overrun}, 32'd0);
    stepCycle;

    // Capture while streaming word 3 is an overrun and is dropped.
    setBasic;
    applyStimulus(packExp());
    stepCycle;
    streamWords("ovr", 1'b0, 3, 16'hB000, NN, hs);
    checkOutput("ovr_hs", hs, NN);
    checkOutput("ovr_flag", {31'd0, overrun}, 32'd1);
    checkOutput("ovr_endBusy", {31'd0, busy}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("ovr_idleValid%0d", c), {31'd0, o_valid}, 32'd0);
      checkOutput($sformatf("ovr_sticky%0d", c), {31'd0, overrun}, 32'd1);
      stepCycle;
    end

    // Asynchronous reset mid-stream, away from any clock edge.
    applyStimulus(packExp());
    stepCycle;
    streamWords("mid", 1'b0, -1, '0, NN - 1, hs);
    checkOutput("mid_preLast", {31'd0, o_last}, 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("mid_rstValid", {31'd0, o_valid}, 32'd0);
    checkOutput("mid_rstData", {16'd0, o_data}, 32'd0);
    checkOutput("mid_rstLast", {31'd0, o_last}, 32'd0);
    checkOutput("mid_rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rstOverrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    stepCycle;
    setRamp(16'h0C00);
    applyStimulus(packExp());
    stepCycle;
    streamWords("post", 1'b0, -1, '0, NN, hs);
    checkOutput("post_hs", hs, NN);
    checkOutput("post_endBusy", {31'd0, busy}, 32'd0);
    stepCycle;

`ifdef LAYER_SERIALIZER_ARGMAX_EN
    expWords = '{16'd5, 16'hFFFD, 16'd9, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    applyStimulus(packExp());
    stepCycle;
    streamWords("amax1", 1'b0, -1, '0, NN, hs);
    checkOutput("amax1_pulse", {31'd0, o_max_valid}, 32'd1);
    checkOutput("amax1_idx", {28'd0, o_max_idx}, 32'd2);
    stepCycle;
    checkOutput("amax1_pulseEnd", {31'd0, o_max_valid}, 32'd0);
    checkOutput("amax1_idxHold", {28'd0, o_max_idx}, 32'd2);
    expWords = '{16'hFFF8, 16'hFFFE, 16'hFFFE, 16'hFFF8, 16'hFFF8,
                 16'hFFF8, 16'hFFF8, 16'hFFF8, 16'hFFF8, 16'hFFF8};
    applyStimulus(packExp());
    stepCycle;
    streamWords("amax2", 1'b0, -1, '0, NN, hs);
    checkOutput("amax2_pulse", {31'd0, o_max_valid}, 32'd1);
    checkOutput("amax2_idx", {28'd0, o_max_idx}, 32'd1);
    stepCycle;
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
